fa_serial_ctrl: RTL

- Sequencer that time-shares one single-bit full adder (`fa`) to add two W-bit operands bit-serially, LSB first.
- One `fa` instance is stepped over W cycles. The carry between bits is held in a register.
- Used where area beats latency. The lab uses it to move from the combinational 1-bit adder to a clocked multi-bit datapath.

---
 rtl/fa_serial_ctrl_if.sv | 24 ++
 rtl/fa_serial_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fa_serial_ctrl_if.sv
// Handshake and data bundle for the bit-serial adder sequencer.
// The requester drives the operands and start; the sequencer returns status and the result.
interface fa_serial_ctrl_if #(
    parameter int W = 8
);
    logic         start;
    logic         Cin;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Cout;

    modport master (
        output start, Cin, A, B,
        input  busy, done, Sum, Cout
    );

    modport slave (
        input  start, Cin, A, B,
        output busy, done, Sum, Cout
    );
endinterface

// File: rtl/fa_serial_ctrl.sv
// Bit-serial W-bit adder: one full adder is stepped LSB first over W cycles,
// with the inter-bit carry held in a register and the result committed all at once.
module fa (
    input  logic Cin,
    input  logic A,
    input  logic B,
    output logic Cout,
    output logic Sum
);
    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module fa_serial_ctrl #(
    parameter int W = 8
) (
    input logic            clk,
    input logic            rst,
    fa_serial_ctrl_if.slave bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          load, step, commit;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_sr, b_sr, s_sr, s_nxt;
    logic          carry;
    logic          fa_sum, fa_cout;
    logic [W-1:0]  sum_q;
    logic          cout_q;

    fa u_fa (
        .Cin  (carry),
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Cout (fa_cout),
        .Sum  (fa_sum)
    );

    // Partial sum including the bit produced this cycle; committed whole at the last step.
    assign s_nxt = (s_sr >> 1) | (W'(fa_sum) << (W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == CW'(W - 1)) begin
                    commit    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (load) begin
            a_sr  <= bus.A;
            b_sr  <= bus.B;
            carry <= bus.Cin;
            cnt   <= '0;
        end else if (step) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            s_sr  <= s_nxt;
            carry <= fa_cout;
            // Counter returns to zero only on the exit step, whatever W is.
            cnt   <= commit ? '0 : cnt + 1'b1;
            if (commit) begin
                sum_q  <= s_nxt;
                cout_q <= fa_cout;
            end
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
endmodule
